sbox_scheduler: RTL and testbench

Time-multiplexed SubBytes engine and S-box arbiter for the iterative AES core. It performs a full 128-bit SubBytes with four shared `SBox` instances over four slice cycles, so a round needs four S-boxes instead of sixteen. It also arbitrates those same S-boxes between the round datapath (128-bit state jobs) and the key expansion unit (32-bit SubWord requests). It sits between the round controller and the ShiftRows stage, with a side port to key expansion.

---
 rtl/sbox_scheduler.sv | 158 +++++++++++++++
 tb/tb_sbox_scheduler.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sbox_scheduler.sv
// Time-multiplexed AES SubBytes engine: four shared S-boxes process a 128-bit state
// in four 32-bit slices and are round-robin shared with key-expansion SubWord requests.

module SBox (
    input  logic [7:0] in_toSub,
    output logic [7:0] out_Subed
);
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254; maps 0 to 0 as the S-box requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] s;
        r = 8'h01;
        s = a;
        for (int k = 1; k < 8; k++) begin
            s = gf_mul(s, s);
            r = gf_mul(r, s);
        end
        return r;
    endfunction

    logic [7:0] w_inv;

    assign w_inv     = gf_inv(in_toSub);
    assign out_Subed = w_inv ^ {w_inv[6:0], w_inv[7]} ^ {w_inv[5:0], w_inv[7:6]}
                     ^ {w_inv[4:0], w_inv[7:5]} ^ {w_inv[3:0], w_inv[7:4]} ^ 8'h63;
endmodule

module sbox_scheduler (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_state_valid,
    output logic         o_state_ready,
    input  logic [127:0] i_state,
    output logic         o_state_valid,
    input  logic         i_out_ready,
    output logic [127:0] o_state,
    input  logic         i_word_valid,
    input  logic [31:0]  i_word,
    output logic         o_word_gnt,
    output logic         o_word_done,
    output logic [31:0]  o_word
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t       r_state;
    state_t       w_state_nxt;
    logic [127:0] r_state_in;
    logic [127:0] r_state_out;
    logic [1:0]   r_slice_cnt;
    logic         r_last_word;
    logic         r_alive;
    logic [31:0]  r_word;
    logic         r_word_done;

    logic         w_run;
    logic         w_contested;
    logic         w_word_win;
    logic         w_state_win;
    logic         w_accept;
    logic [31:0]  w_slice;
    logic [31:0]  w_sub_in;
    logic [31:0]  w_sub_out;

    assign w_run       = (r_state == S_RUN);
    assign w_contested = i_word_valid & w_run;
    // Word wins when uncontested, or on a contested cycle when the state job had the last turn.
    assign w_word_win  = i_word_valid & (~w_run | ~r_last_word);
    assign w_state_win = w_run & ~w_word_win;
    // r_alive holds ready low until the first clock after reset release.
    assign w_accept    = i_state_valid & r_alive & (r_state == S_IDLE);

    always_comb begin
        w_slice = r_state_in[127:96];
        case (r_slice_cnt)
            2'd0: w_slice = r_state_in[127:96];
            2'd1: w_slice = r_state_in[95:64];
            2'd2: w_slice = r_state_in[63:32];
            2'd3: w_slice = r_state_in[31:0];
            default: w_slice = r_state_in[127:96];
        endcase
    end

    assign w_sub_in = w_word_win ? i_word : w_slice;

    for (genvar g = 0; g < 4; g++) begin : g_sbox
        SBox u_sbox (
            .in_toSub  (w_sub_in[8*g +: 8]),
            .out_Subed (w_sub_out[8*g +: 8])
        );
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_state_nxt = S_RUN;
            S_RUN:  if (w_state_win && (r_slice_cnt == 2'd3)) w_state_nxt = S_DONE;
            S_DONE: if (i_out_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_alive <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_alive <= 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state_in  <= '0;
            r_state_out <= '0;
            r_slice_cnt <= 2'd0;
            r_last_word <= 1'b0;
            r_word      <= '0;
            r_word_done <= 1'b0;
        end else begin
            r_word_done <= w_word_win;
            if (w_word_win) r_word <= w_sub_out;
            if (w_contested) r_last_word <= w_word_win;
            if (w_accept) begin
                r_state_in  <= i_state;
                r_slice_cnt <= 2'd0;
            end else if (w_state_win) begin
                r_slice_cnt <= r_slice_cnt + 2'd1;
                case (r_slice_cnt)
                    2'd0: r_state_out[127:96] <= w_sub_out;
                    2'd1: r_state_out[95:64]  <= w_sub_out;
                    2'd2: r_state_out[63:32]  <= w_sub_out;
                    2'd3: r_state_out[31:0]   <= w_sub_out;
                    default: r_state_out[127:96] <= w_sub_out;
                endcase
            end
        end
    end

    assign o_state_ready = r_alive & (r_state == S_IDLE);
    assign o_state_valid = (r_state == S_DONE);
    assign o_state       = r_state_out;
    assign o_word_gnt    = w_word_win;
    assign o_word_done   = r_word_done;
    assign o_word        = r_word;
endmodule

// File: tb/tb_sbox_scheduler.sv
// Self-checking bench for sbox_scheduler: cycle-level reference model built from
// job phases, remaining-slice counts and a turn flag, with a generator-derived S-box table.

module tb_sbox_scheduler;
    logic         clk = 1'b0;
    logic         rst_n;
    logic         sv, ordy, wv;
    logic [127:0] sin;
    logic [31:0]  win;
    logic         sr, ov, gnt, wd;
    logic [127:0] so;
    logic [31:0]  wo;

    always #5 clk = ~clk;

    sbox_scheduler dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_state_valid (sv),
        .o_state_ready (sr),
        .i_state       (sin),
        .o_state_valid (ov),
        .i_out_ready   (ordy),
        .o_state       (so),
        .i_word_valid  (wv),
        .i_word        (win),
        .o_word_gnt    (gnt),
        .o_word_done   (wd),
        .o_word        (wo)
    );

    logic [7:0] sb [256];
    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: phase 0 idle, 1 running, 2 result held.
    int           m_ph = 0;
    int           m_left = 0;
    bit           m_lw = 1'b0;
    bit           m_alive = 1'b0;
    bit           m_wdone = 1'b0;
    logic [31:0]  m_word = '0;
    logic [127:0] m_res = '0;
    int           lat = 0;
    int           last_lat = 0;

    task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic build_sbox();
        logic [7:0] p, q, x;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ (p << 1) ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ (q << 1);
            q = q ^ (q << 2);
            q = q ^ (q << 4);
            if (q[7]) q = q ^ 8'h09;
            x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
            sb[p] = x ^ 8'h63;
        end while (p != 8'h01);
        sb[0] = 8'h63;
    endtask

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = sb[w[8*i +: 8]];
        return r;
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[8*i +: 8] = sb[s[8*i +: 8]];
        return r;
    endfunction

    // Called at posedge+1 with inputs already driven; returns at the next posedge+1.
    task automatic cycle(input string tag);
        bit e_gnt, e_acc, e_swin;
        #1;
        e_gnt  = wv && (m_ph != 1 || !m_lw);
        e_acc  = sv && m_alive && (m_ph == 0);
        e_swin = (m_ph == 1) && !e_gnt;
        check({tag, ".gnt"},   gnt, e_gnt);
        check({tag, ".ready"}, sr,  m_alive && (m_ph == 0));
        check({tag, ".valid"}, ov,  m_ph == 2);
        check({tag, ".wdone"}, wd,  m_wdone);
        check({tag, ".word"},  wo,  m_word);
        if (m_ph == 2) check({tag, ".state"}, so, m_res);
        @(posedge clk);
        m_alive = 1'b1;
        m_wdone = e_gnt;
        if (e_gnt) m_word = sub_word(win);
        if (wv && m_ph == 1) m_lw = e_gnt;
        case (m_ph)
            0: if (e_acc) begin
                m_ph = 1; m_left = 4; m_res = sub_bytes(sin); lat = 0;
            end
            1: begin
                lat++;
                if (e_swin) begin
                    m_left--;
                    if (m_left == 0) begin m_ph = 2; last_lat = lat; end
                end
            end
            default: if (ordy) m_ph = 0;
        endcase
        #1;
    endtask

    // word_mode: 0 no words, 1 word held valid, 2 random words
    task automatic run_to_done(input string tag, input int word_mode);
        int n;
        n = 0;
        while (m_ph != 2 && n < 20) begin
            wv  = (word_mode == 1) || (word_mode == 2 && $urandom_range(0, 1) == 1);
            win = $urandom;
            cycle(tag);
            n++;
        end
        if (m_ph != 2) check({tag, ".timeout"}, 1'b1, 1'b0);
        wv = 1'b0;
    endtask

    task automatic reset_async(input string tag);
        #2 rst_n = 1'b0;
        #1;
        check({tag, ".rst_valid"}, ov, 1'b0);
        check({tag, ".rst_ready"}, sr, 1'b0);
        check({tag, ".rst_wdone"}, wd, 1'b0);
        check({tag, ".rst_word"},  wo, 32'h0);
        check({tag, ".rst_state"}, so, 128'h0);
        m_ph = 0; m_left = 0; m_lw = 1'b0; m_alive = 1'b0;
        m_wdone = 1'b0; m_word = '0; m_res = '0;
        sv = 1'b0; wv = 1'b0; ordy = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        build_sbox();
        rst_n = 1'b1; sv = 1'b0; ordy = 1'b0; wv = 1'b0; sin = '0; win = '0;
        #1 rst_n = 1'b0;
        #1;
        check("por.valid", ov, 1'b0);
        check("por.state", so, 128'h0);
        check("por.word",  wo, 32'h0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        cycle("rel");
        cycle("idle");

        // Known-answer job with no word traffic
        sin = 128'h000102030405060708090a0b0c0d0e0f;
        sv = 1'b1;
        cycle("kat1.acc");
        sv = 1'b0;
        run_to_done("kat1", 0);
        check("kat1.lat", last_lat, 4);
        check("kat1.res", so, 128'h637c777bf26b6fc53001672bfed7ab76);
        repeat (3) cycle("kat1.hold");
        ordy = 1'b1;
        cycle("kat1.hs");
        ordy = 1'b0;

        // Single word in idle
        wv = 1'b1; win = 32'hcf4f3c09;
        #1 check("w1.gnt", gnt, 1'b1);
        cycle("w1.req");
        wv = 1'b0;
        check("w1.word", wo, 32'h8a84eb01);
        check("w1.done", wd, 1'b1);
        cycle("w1.after");
        cycle("w1.idle");

        // Job with a word held valid throughout RUN
        sin = 128'h000102030405060708090a0b0c0d0e0f;
        sv = 1'b1;
        cycle("kat2.acc");
        sv = 1'b0;
        run_to_done("kat2", 1);
        check("kat2.lat", last_lat, 8);
        check("kat2.res", so, 128'h637c777bf26b6fc53001672bfed7ab76);
        ordy = 1'b1;
        cycle("kat2.hs");
        ordy = 1'b0;

        // Backpressure with a pending job and word traffic
        sin = {$urandom, $urandom, $urandom, $urandom};
        sv = 1'b1;
        cycle("bp.acc");
        run_to_done("bp.run", 2);
        for (int i = 0; i < 10; i++) begin
            wv = $urandom_range(0, 1); win = $urandom;
            sin = {$urandom, $urandom, $urandom, $urandom};
            cycle("bp.hold");
        end
        wv = 1'b0;
        ordy = 1'b1;
        cycle("bp.hs");
        ordy = 1'b0;
        cycle("bp.reacc");
        sv = 1'b0;
        check("bp.running", ov | sr, 1'b0);
        run_to_done("bp.job2", 0);
        ordy = 1'b1;
        cycle("bp.hs2");
        ordy = 1'b0;

        // Reset mid-RUN at slice 2
        sin = {$urandom, $urandom, $urandom, $urandom};
        sv = 1'b1;
        cycle("mr.acc");
        sv = 1'b0;
        cycle("mr.s0");
        cycle("mr.s1");
        check("mr.left", m_left, 2);
        reset_async("mr");
        cycle("mr.rel");
        sin = {128{1'b1}};
        sv = 1'b1;
        cycle("ff.acc");
        sv = 1'b0;
        run_to_done("ff", 0);
        check("ff.res", so, {16{8'h16}});
        ordy = 1'b1;
        cycle("ff.hs");

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            sv   = $urandom_range(0, 2) == 0;
            ordy = $urandom_range(0, 2) != 0;
            wv   = $urandom_range(0, 1);
            sin  = {$urandom, $urandom, $urandom, $urandom};
            win  = $urandom;
            cycle("rnd");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
